// File: rtl/count_bcd_display.sv
// Converts each new 8-bit count to BCD with a shift-per-clock double-dabble engine and scans it onto a 3-digit 7-segment display.
// Build option: LEADING_ZERO_BLANK_EN blanks the leading zero digits (hundreds, and tens when hundreds is also zero).
module count_bcd_display #(
   parameter int SCAN_DIV = 1000,
   parameter int SCAN_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  count_in,
   input  logic        count_vld,
   output logic        busy,
   output logic [11:0] bcd_out,
   output logic        bcd_vld,
   output logic [6:0]  seg_out,
   output logic [2:0]  dig_sel
);

   // state | meaning
   // IDLE  | waiting for count_vld (or a pending value left over from DONE)
   // SHIFT | one add-3/shift iteration per clock, 8 in total
   // DONE  | publish accumulator to bcd_out, chain into a pending value if any
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  bin_q, bin_nxt;
   logic [11:0] acc_q, acc_nxt, acc_adj;
   logic [3:0]  iter_q, iter_nxt;
   logic        pend_q, pend_nxt;
   logic [7:0]  pend_val_q, pend_val_nxt;
   logic [11:0] bcd_nxt;
   logic        vld_nxt;

   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        dig_idx;
   logic [3:0]        nib;
   logic [6:0]        seg_nxt;
   logic [2:0]        dig_nxt;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign acc_adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bin_q      <= 8'd0;
         acc_q      <= 12'd0;
         iter_q     <= 4'd0;
         pend_q     <= 1'b0;
         pend_val_q <= 8'd0;
         bcd_out    <= 12'h000;
         bcd_vld    <= 1'b0;
      end else begin
         state      <= state_nxt;
         bin_q      <= bin_nxt;
         acc_q      <= acc_nxt;
         iter_q     <= iter_nxt;
         pend_q     <= pend_nxt;
         pend_val_q <= pend_val_nxt;
         bcd_out    <= bcd_nxt;
         bcd_vld    <= vld_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bin_nxt      = bin_q;
      acc_nxt      = acc_q;
      iter_nxt     = iter_q;
      pend_nxt     = pend_q;
      pend_val_nxt = pend_val_q;
      bcd_nxt      = bcd_out;
      vld_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            // a fresh strobe is newer than anything left pending from DONE
            if (count_vld) begin
               bin_nxt   = count_in;
               acc_nxt   = 12'd0;
               iter_nxt  = 4'd0;
               pend_nxt  = 1'b0;
               state_nxt = ST_SHIFT;
            end else if (pend_q) begin
               bin_nxt   = pend_val_q;
               acc_nxt   = 12'd0;
               iter_nxt  = 4'd0;
               pend_nxt  = 1'b0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {acc_nxt, bin_nxt} = {acc_adj[10:0], bin_q, 1'b0};
            iter_nxt = iter_q + 4'd1;
            if (iter_q == 4'd7) state_nxt = ST_DONE;
            if (count_vld) begin
               pend_nxt     = 1'b1;
               pend_val_nxt = count_in;
            end
         end
         ST_DONE: begin
            bcd_nxt = acc_q;
            vld_nxt = 1'b1;
            if (pend_q) begin
               bin_nxt   = pend_val_q;
               acc_nxt   = 12'd0;
               iter_nxt  = 4'd0;
               pend_nxt  = 1'b0;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
            if (count_vld) begin
               pend_nxt     = 1'b1;
               pend_val_nxt = count_in;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   always_comb begin
      nib     = bcd_out[3:0];
      dig_nxt = 3'b001;
      case (dig_idx)
         2'd1: begin
            nib     = bcd_out[7:4];
            dig_nxt = 3'b010;
         end
         2'd2: begin
            nib     = bcd_out[11:8];
            dig_nxt = 3'b100;
         end
         default: ;
      endcase
      seg_nxt = seg_decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_idx == 2'd2 && bcd_out[11:8] == 4'd0) seg_nxt = 7'h00;
      if (dig_idx == 2'd1 && bcd_out[11:4] == 8'd0) seg_nxt = 7'h00;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out <= 7'h00;
         dig_sel <= 3'b000;
      end else begin
         seg_out <= seg_nxt;
         dig_sel <= dig_nxt;
      end
   end

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: conversion latency, value sweep, chaining, reset abort, display scan.
module tb_count_bcd_display;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  count_in = 8'd0;
   logic        count_vld = 1'b0;
   logic        busy;
   logic [11:0] bcd_out;
   logic        bcd_vld;
   logic [6:0]  seg_out;
   logic [2:0]  dig_sel;

   int n_cmp = 0;
   int n_err = 0;
   int vld_cnt = 0;
   logic [11:0] exp_q[$];
   logic [6:0]  seg_tab [10];
   logic [6:0]  lz;

   count_bcd_display #(.SCAN_DIV(SCAN_DIV), .SCAN_W(4)) dut (
      .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
      .busy(busy), .bcd_out(bcd_out), .bcd_vld(bcd_vld),
      .seg_out(seg_out), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bcd_vld === 1'b1) vld_cnt++;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h want 000", bcd_out); end
      n_cmp++; if (bcd_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bcd_vld); end
      n_cmp++; if (seg_out !== 7'h00) begin n_err++; $display("FAIL reset_seg: got %h want 00", seg_out); end
      n_cmp++; if (dig_sel !== 3'b000) begin n_err++; $display("FAIL reset_dig: got %b want 000", dig_sel); end
      rst = 1'b0;
      tick;
      n_cmp++; if (dig_sel !== 3'b001) begin n_err++; $display("FAIL first_dig: got %b want 001", dig_sel); end
      n_cmp++; if (seg_out !== 7'h3F) begin n_err++; $display("FAIL first_seg: got %h want 3F", seg_out); end
   endtask

   task automatic test_latency;
      logic [11:0] e;
      count_in = 8'd255; count_vld = 1'b1;
      exp_q.push_back(to_bcd(255));
      tick;
      count_vld = 1'b0;
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (busy !== 1'b1 || bcd_vld !== 1'b0) begin
            n_err++; $display("FAIL lat_busy cycle %0d: busy=%b vld=%b want busy=1 vld=0", i, busy, bcd_vld);
         end
         tick;
      end
      n_cmp++; if (bcd_vld !== 1'b1) begin n_err++; $display("FAIL lat_vld: got %b want 1", bcd_vld); end
      e = exp_q.pop_front();
      n_cmp++; if (bcd_out !== e) begin n_err++; $display("FAIL lat_bcd: got %h want %h", bcd_out, e); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lat_idle: got %b want 0", busy); end
      tick;
      n_cmp++; if (bcd_vld !== 1'b0) begin n_err++; $display("FAIL lat_pulse: got %b want 0", bcd_vld); end
      n_cmp++; if (bcd_out !== e) begin n_err++; $display("FAIL lat_hold: got %h want %h", bcd_out, e); end
   endtask

   task automatic test_boundaries;
      int vals[4] = '{0, 100, 99, 255};
      logic [11:0] e;
      int t;
      foreach (vals[k]) begin
         count_in = 8'(vals[k]); count_vld = 1'b1;
         exp_q.push_back(to_bcd(vals[k]));
         tick;
         count_vld = 1'b0;
         t = 0;
         while (bcd_vld !== 1'b1 && t < 20) begin tick; t++; end
         e = exp_q.pop_front();
         n_cmp++;
         if (bcd_vld !== 1'b1) begin
            n_err++; $display("FAIL bound_timeout %0d: vld=%b want 1", vals[k], bcd_vld);
         end else if (bcd_out !== e) begin
            n_err++; $display("FAIL bound_bcd %0d: got %h want %h", vals[k], bcd_out, e);
         end
         tick;
      end
   endtask

   task automatic test_sweep;
      logic [11:0] e;
      int t;
      for (int v = 0; v < 256; v++) begin
         count_in = 8'(v); count_vld = 1'b1;
         exp_q.push_back(to_bcd(v));
         tick;
         count_vld = 1'b0;
         t = 0;
         while (bcd_vld !== 1'b1 && t < 20) begin tick; t++; end
         e = exp_q.pop_front();
         n_cmp++;
         if (bcd_vld !== 1'b1) begin
            n_err++; $display("FAIL sweep_timeout %0d: vld=%b want 1", v, bcd_vld);
         end else if (bcd_out !== e) begin
            n_err++; $display("FAIL sweep_bcd %0d: got %h want %h", v, bcd_out, e);
         end
         tick;
      end
   endtask

   task automatic test_back_to_back;
      int rel;
      int hits;
      int want_rel[2] = '{9, 18};
      logic [11:0] e;
      hits = 0;
      count_in = 8'd12; count_vld = 1'b1;
      exp_q.push_back(to_bcd(12));
      tick; rel = 0;
      count_vld = 1'b0;
      tick; rel++;
      tick; rel++;
      count_in = 8'd34; count_vld = 1'b1;
      tick; rel++;
      count_in = 8'd56;
      exp_q.push_back(to_bcd(56));
      tick; rel++;
      count_vld = 1'b0;
      while (rel < 30) begin
         tick; rel++;
         if (bcd_vld === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
            n_cmp++; if (bcd_out !== e) begin n_err++; $display("FAIL chain_bcd: got %h want %h", bcd_out, e); end
            if (hits < 2) begin
               n_cmp++;
               if (rel != want_rel[hits]) begin n_err++; $display("FAIL chain_time: got %0d want %0d", rel, want_rel[hits]); end
            end
            hits++;
         end
      end
      n_cmp++; if (hits != 2) begin n_err++; $display("FAIL chain_count: got %0d want 2", hits); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL chain_queue: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid;
      int base;
      base = vld_cnt;
      count_in = 8'd77; count_vld = 1'b1;
      tick;
      count_in = 8'd200;
      tick;
      count_vld = 1'b0;
      tick; tick; tick;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_cmp++;
         if (busy !== 1'b0 || bcd_out !== 12'h000 || bcd_vld !== 1'b0 || dig_sel !== 3'b000 || seg_out !== 7'h00) begin
            n_err++;
            $display("FAIL rstmid_hold: busy=%b bcd=%h vld=%b dig=%b seg=%h want 0 000 0 000 00", busy, bcd_out, bcd_vld, dig_sel, seg_out);
         end
      end
      rst = 1'b0;
      tick;
      n_cmp++; if (dig_sel !== 3'b001 || seg_out !== 7'h3F) begin n_err++; $display("FAIL rstmid_first: dig=%b seg=%h want 001 3F", dig_sel, seg_out); end
      repeat (25) tick;
      n_cmp++; if (vld_cnt != base) begin n_err++; $display("FAIL rstmid_vld: got %0d pulses want 0", vld_cnt - base); end
      n_cmp++; if (bcd_out !== 12'h000) begin n_err++; $display("FAIL rstmid_bcd: got %h want 000", bcd_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
   endtask

   task automatic test_scan(input int v, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
      logic [11:0] e;
      logic [2:0]  prev;
      logic [2:0]  want_dig;
      logic [6:0]  want_seg;
      int t;
      count_in = 8'(v); count_vld = 1'b1;
      exp_q.push_back(to_bcd(v));
      tick;
      count_vld = 1'b0;
      t = 0;
      while (bcd_vld !== 1'b1 && t < 20) begin tick; t++; end
      e = exp_q.pop_front();
      n_cmp++; if (bcd_out !== e) begin n_err++; $display("FAIL scan_bcd %0d: got %h want %h", v, bcd_out, e); end
      prev = dig_sel;
      tick;
      t = 0;
      while (!(dig_sel === 3'b001 && prev !== 3'b001) && t < 30) begin prev = dig_sel; tick; t++; end
      n_cmp++; if (dig_sel !== 3'b001) begin n_err++; $display("FAIL scan_sync %0d: got %b want 001", v, dig_sel); end
      for (int r = 0; r < 2; r++) begin
         for (int d = 0; d < 3; d++) begin
            want_dig = (d == 0) ? 3'b001 : (d == 1) ? 3'b010 : 3'b100;
            want_seg = (d == 0) ? s0 : (d == 1) ? s1 : s2;
            for (int c = 0; c < SCAN_DIV; c++) begin
               n_cmp++;
               if (dig_sel !== want_dig || seg_out !== want_seg) begin
                  n_err++;
                  $display("FAIL scan %0d digit %0d: dig=%b seg=%h want %b %h", v, d, dig_sel, seg_out, want_dig, want_seg);
               end
               tick;
            end
         end
      end
   endtask

   initial begin
      seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66;
      seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07; seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
`ifdef LEADING_ZERO_BLANK_EN
      lz = 7'h00;
`else
      lz = 7'h3F;
`endif
      test_reset;
      test_latency;
      test_boundaries;
      test_sweep;
      test_back_to_back;
      test_reset_mid;
      test_scan(123, seg_tab[3], seg_tab[2], seg_tab[1]);
      test_scan(7, seg_tab[7], lz, lz);
      test_scan(105, seg_tab[5], seg_tab[0], seg_tab[1]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the 8-bit up/down counter value.
- Converts each new 8-bit count to 3-digit BCD using a sequential double-dabble engine (one shift per clock).
- Holds the result and drives a time-multiplexed 3-digit 7-segment display.
- Sits between the counter core and the top-level output pins (uo_out / uio_out).

Parameters:
- SCAN_DIV, default 1000: clk cycles each digit stays selected; legal range 2..65535.
- SCAN_W, default 16: width of the scan divider counter; must satisfy 2^SCAN_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- count_in  in  8  unsigned binary count from the counter.
- count_vld  in  1  one-cycle strobe: count_in is new.
- busy  out  1  conversion in progress (SHIFT or DONE state).
- bcd_out  out  12  {hundreds, tens, ones} BCD of the last completed conversion.
- bcd_vld  out  1  one-cycle pulse when bcd_out updates.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- dig_sel  out  3  one-hot digit enable, active-high, registered; bit0=ones, bit1=tens, bit2=hundreds.

Behaviour:
- Reset values (rst=1 at an edge): state=IDLE, busy=0, bcd_out=12'h000, bcd_vld=0, pending=0, scan counter=0, digit index=0, seg_out=7'h00, dig_sel=3'b000.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with count_vld=1:
  - Latch count_in into an 8-bit shift register.
  - Clear the 12-bit BCD accumulator and set iteration counter=0.
  - Go to SHIFT.
- SHIFT, each cycle:
  - For each BCD nibble >= 5, add 3.
  - Then shift {bcd, bin} left by 1 and increment the iteration counter.
  - After the 8th shift, go to DONE.
- DONE, one cycle:
  - bcd_out <= accumulator; bcd_vld=1.
  - If pending=1, start a new conversion from the pending value (enter SHIFT directly) and clear pending; else go to IDLE.
- Latency: count_vld sampled at edge N gives bcd_vld=1 in the cycle after edge N+9; bcd_out valid in that same cycle.
- busy=1 in SHIFT and DONE; busy=0 in IDLE.
- count_vld while busy:
  - Value is captured in a one-deep pending register and pending is set.
  - A further count_vld overwrites the pending value (newest wins); no error flag.
  - count_vld in DONE is also captured as pending. This is the only path taken when pending was already set.
- Width rules:
  - Max input 255 gives 12'h255.
  - The hundreds nibble never exceeds 2; no overflow is possible.
- bcd_out holds its value between conversions; it never shows partial results.
- Scanner (independent of the FSM, free-running out of reset):
  - The scan counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index advances 0→1→2→0.
- Display registers, every cycle after reset:
  - dig_sel <= one-hot(index).
  - seg_out <= decode(bcd_out nibble[index]).
  - First valid display: cycle after reset deassertion, dig_sel=3'b001, seg_out=7'h3F.
- Decode table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values A–F are unreachable; decode them to 7'h00.
- A bcd_out update mid-scan takes effect on seg_out at the next edge; there is no wait for scan wrap.
- Reset mid-conversion:
  - Abort, discard the pending value, return all outputs to their reset values.
  - No bcd_vld pulse is produced.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit shows seg_out=7'h00 when its nibble=0.
  - Tens digit shows 7'h00 when the hundreds and tens nibbles are both 0.
  - The ones digit is never blanked.
  - dig_sel still scans all three digits.
- Undefined: all digits are always decoded, so leading zeros are shown as 7'h3F.

Test Plan:
- Reset, then count_in=8'd255 with count_vld pulse at edge N → bcd_vld=1 exactly after edge N+9, bcd_out=12'h255, busy high for 9 cycles, then 0.
- count_in=0 → bcd_out=12'h000. count_in=8'd100 → 12'h100. count_in=8'd99 → 12'h099. Exhaustive 0..255 sweep matches a reference BCD model.
- Pulse count_vld with 12 and, 3 cycles later, 34 and then 56 (both while busy) → bcd_vld for 012, then immediately chained conversion gives 056 at 9 cycles after DONE; 034 never appears.
- Assert rst at SHIFT iteration 4 with 200 pending → bcd_out=000, bcd_vld never pulses, busy=0, dig_sel=000 while rst held.
- SCAN_DIV=4, bcd_out=12'h123 → dig_sel sequence 001,010,100 each for 4 cycles with seg_out 4F, 5B, 06, repeating.
- LEADING_ZERO_BLANK_EN defined, count 7 → hundreds and tens seg_out=00, ones=07. Count 105 → 06, 3F, 6D (tens zero shown). Undefined, count 7 → 3F, 3F, 07.
